// File: rtl/serial_alu_seq.sv
// serial_alu_seq
// Bit-serial N-bit ALU sequencer built around one 1-bit ALU slice with a
// registered carry/borrow chain bit. An operand pair and opcode are accepted
// through a valid/ready handshake. The operands are then walked LSB-first,
// one bit per clock, and the N-bit result is presented with carry/borrow
// and zero flags.
//
// state | meaning
// IDLE  | start_ready=1, waiting for start_valid
// RUN   | one slice evaluation per cycle, bit[cnt]
// DONE  | outputs just loaded, done=1 for this cycle
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start_valid  request to start an operation
//   start_ready  high only in IDLE
//   op           opcode (ADD SUB INC DEC AND OR XOR NOT), sampled on acceptance
//   a, b         operands, sampled on acceptance
//   result       registered result
//   cout         final carry (ADD/INC) or borrow (SUB/DEC), 0 for logic ops
//   zero         result == 0
//   done         one-cycle pulse when result/cout/zero update
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             chain;
  logic [CW-1:0]    cnt;

  logic             abit;
  logic             bbit;
  logic             sbit;
  logic             cnext;
  logic [WIDTH-1:0] res_next;

  assign start_ready = (state == IDLE);

  // 1-bit slice. INC/DEC reuse the ADD/SUB chains with b zeroed at
  // acceptance and the chain bit preset to 1.
  always_comb begin
    abit  = a_sh[0];
    bbit  = b_sh[0];
    sbit  = 1'b0;
    cnext = 1'b0;
    case (op_r)
      OP_ADD, OP_INC: begin
        sbit  = abit ^ bbit ^ chain;
        cnext = (abit & bbit) | (chain & (abit ^ bbit));
      end
      OP_SUB, OP_DEC: begin
        sbit  = abit ^ bbit ^ chain;
        cnext = (~abit & bbit) | (~(abit ^ bbit) & chain);
      end
      OP_AND:  sbit = abit & bbit;
      OP_OR:   sbit = abit | bbit;
      OP_XOR:  sbit = abit ^ bbit;
      default: sbit = ~abit;
    endcase
    // result bits enter at the MSB so that after WIDTH shifts bit 0 is LSB
    res_next = {sbit, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= 3'b000;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      chain  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_valid) begin
            op_r   <= op;
            a_sh   <= a;
            b_sh   <= ((op == OP_INC) || (op == OP_DEC)) ? '0 : b;
            chain  <= (op == OP_INC) || (op == OP_DEC);
            res_sh <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          chain  <= cnext;
          if (cnt == LAST) begin
            // outputs load together with the last slice evaluation
            result <= res_next;
            cout   <= cnext;
            zero   <= (res_next == '0);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         done;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b),
    .result(result), .cout(cout), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_r = '0;
  logic last_c = 1'b0;
  logic last_z = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on whole words.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] t;
    e.c = 1'b0;
    e.acc = 0;
    case (o)
      3'd0: begin t = {1'b0, x} + {1'b0, y}; e.r = t[W-1:0]; e.c = t[W]; end
      3'd1: begin e.r = x - y; e.c = (x < y); end
      3'd2: begin t = {1'b0, x} + 1; e.r = t[W-1:0]; e.c = t[W]; end
      3'd3: begin e.r = x - 1; e.c = (x == 0); end
      3'd4: e.r = x & y;
      3'd5: e.r = x | y;
      3'd6: e.r = x ^ y;
      default: e.r = ~x;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_r = '0;
        last_c = 1'b0;
        last_z = 1'b0;
      end else begin
        if (q.size() != 0) chk("ready_low_busy", 32'(start_ready), 32'd0);
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("result", 32'(result), 32'(e.r));
            chk("cout", 32'(cout), 32'(e.c));
            chk("zero", 32'(zero), 32'(e.z));
            chk("done_latency", 32'(cyc - e.acc), 32'(W));
            last_r = e.r;
            last_c = e.c;
            last_z = e.z;
          end
        end else begin
          chk("hold_result", 32'(result), 32'(last_r));
          chk("hold_cout", 32'(cout), 32'(last_c));
          chk("hold_zero", 32'(zero), 32'(last_z));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold, input bit push, output int acc);
    int n;
    exp_t e;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!start_ready && n < 200) begin
      op = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if (!hold) start_valid = 1'($urandom_range(0, 1));
      n++;
      @(negedge clk);
    end
    if (!start_ready) begin
      chk("ready_timeout", 32'(start_ready), 32'd1);
      start_valid = 1'b0;
      return;
    end
    start_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      e = model(o, x, y);
      e.acc = acc;
      q.push_back(e);
    end
    if (!hold) start_valid = 1'b0;
    op = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  initial begin
    int acc;
    int prev;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    issue(3'd0, 8'hFF, 8'h01, 0, 1, acc);
    issue(3'd3, 8'h00, 8'h5A, 0, 1, acc);
    issue(3'd3, 8'h10, 8'h00, 0, 1, acc);
    issue(3'd1, 8'h05, 8'h07, 0, 1, acc);
    issue(3'd1, 8'h07, 8'h07, 0, 1, acc);
    issue(3'd6, 8'hA5, 8'h0F, 0, 1, acc);
    issue(3'd7, 8'h3C, 8'h99, 0, 1, acc);
    issue(3'd2, 8'h7F, 8'h00, 0, 1, acc);

    // abort an ADD with reset sampled at its 4th RUN edge
    issue(3'd0, 8'h12, 8'h34, 0, 0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    issue(3'd0, 8'h12, 8'h34, 0, 1, acc);

    // start_valid held high, alternating ops
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      issue((i % 2 == 0) ? 3'd0 : 3'd1, W'($urandom), W'($urandom), 1, 1, acc);
      if (i > 0) chk("accept_spacing", 32'(acc - prev), 32'(W + 2));
      prev = acc;
    end
    start_valid = 1'b0;

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom), W'($urandom), W'($urandom), 0, 1, acc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
